// File: rtl/pong_pkg.sv
// pong_pkg: shared timing constants for the Pong core.
package pong_pkg;
  localparam int DIV_W = 23;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t GAME_DIV = div_t'(120000);
  localparam div_t FLASH_DIV = div_t'(3400000);
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divisor-driven strobe/toggle channel with step override.
module tick_channel import pong_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic step,
  input  div_t div,
  output logic tick,
  output logic toggle
);
  div_t cnt;
  logic wrap;
  // >= rather than == so a divisor lowered below cnt still wraps next cycle
  always_comb wrap = step | (run & (cnt >= div));
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
      toggle <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : run ? cnt + 1'b1 : cnt;
      tick <= wrap;
      toggle <= toggle ^ wrap;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: N_CH programmable tick channels with release-toggled pause,
// single-step while paused and a free-running tone counter.
module tick_scheduler import pong_pkg::*; #(
  parameter int N_CH = 4,
  parameter int TONE_W = 16,
  parameter logic [N_CH-1:0] STEP_MASK = N_CH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_btn,
  input  logic                  step_pulse,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*DIV_W-1:0] div_i,
  output logic [N_CH-1:0]       tick_o,
  output logic [N_CH-1:0]       toggle_o,
  output logic                  paused_o,
  output logic [TONE_W-1:0]     tone_o
);
  logic btn_prev;
  always_ff @(posedge clk)
    if (rst) begin
      btn_prev <= 1'b0;
      paused_o <= 1'b0;
      tone_o <= '0;
    end else begin
      btn_prev <= pause_btn;
      paused_o <= paused_o ^ (btn_prev & ~pause_btn);
      tone_o <= tone_o + 1'b1;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_channel u_ch (
      .clk(clk),
      .rst(rst),
      .run(~paused_o & ch_en[i]),
      .step(step_pulse & paused_o & ch_en[i] & STEP_MASK[i]),
      .div(div_i[i*DIV_W +: DIV_W]),
      .tick(tick_o[i]),
      .toggle(toggle_o[i])
    );
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed and random checks against a behavioural model.
module tb_tick_scheduler;
  import pong_pkg::*;
  localparam int N = 4;
  localparam int TW = 6;
  logic clk = 1'b0;
  logic rst, pause_btn, step_pulse;
  logic [N-1:0] ch_en;
  logic [N*DIV_W-1:0] div_i;
  logic [N-1:0] tick_o, toggle_o;
  logic paused_o;
  logic [TW-1:0] tone_o;
  int unsigned divs[N];
  int unsigned m_cnt[N];
  bit m_tick[N], m_tog[N];
  bit m_paused, m_prev;
  int unsigned m_tone;
  int n_chk = 0, n_fail = 0;
  localparam logic [N-1:0] MASK = 4'b0001;

  always #5 clk = ~clk;

  tick_scheduler #(.N_CH(N), .TONE_W(TW), .STEP_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .pause_btn(pause_btn), .step_pulse(step_pulse),
    .ch_en(ch_en), .div_i(div_i), .tick_o(tick_o), .toggle_o(toggle_o),
    .paused_o(paused_o), .tone_o(tone_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input int unsigned d);
    divs[ch] = d;
    div_i[ch*DIV_W +: DIV_W] = DIV_W'(d);
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit stepping, running;
      stepping = step_pulse && m_paused && MASK[i] && ch_en[i];
      running = !m_paused && ch_en[i];
      m_tick[i] = 0;
      if (stepping || (running && m_cnt[i] >= divs[i])) begin
        m_cnt[i] = 0;
        m_tick[i] = 1;
        m_tog[i] = !m_tog[i];
      end else if (running) m_cnt[i]++;
    end
    if (m_prev && !pause_btn) m_paused = !m_paused;
    m_prev = pause_btn;
    m_tone = (m_tone + 1) % (1 << TW);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_tick[i] = 0; m_tog[i] = 0;
      end
      m_paused = 0; m_prev = 0; m_tone = 0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] et, eg;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      et[i] = m_tick[i];
      eg[i] = m_tog[i];
    end
    chk("tick", 32'(tick_o), 32'(et));
    chk("toggle", 32'(toggle_o), 32'(eg));
    chk("paused", 32'(paused_o), 32'(m_paused));
    chk("tone", 32'(tone_o), m_tone);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1; pause_btn = 0; step_pulse = 0; ch_en = '0; div_i = '0;
    for (int i = 0; i < N; i++) set_div(i, 0);
    cycle();
    chk("reset_tone", 32'(tone_o), 0);
    rst = 0;
    set_div(0, 3);
    ch_en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("t1_tick0", 32'(tick_o[0]), (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) chk("t1_tog0", 32'(toggle_o[0]), (k == 8) ? 0 : 1);
    end
    set_div(0, 0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t2_tick0", 32'(tick_o[0]), 1);
    end
    set_div(0, 5);
    cycles(2);
    pause_btn = 1;
    cycles(5);
    pause_btn = 0;
    cycles(2);
    chk("t3_paused", 32'(paused_o), 1);
    cycles(8);
    chk("t3_frozen", 32'(tick_o), 0);
    set_div(1, 5);
    ch_en = 4'b1111;
    step_pulse = 1;
    cycle();
    chk("t4_step", 32'(tick_o), 32'(4'b0001));
    step_pulse = 0;
    cycles(2);
    pause_btn = 1;
    cycles(2);
    pause_btn = 0;
    cycles(2);
    chk("t3_resume", 32'(paused_o), 0);
    step_pulse = 1;
    cycles(3);
    step_pulse = 0;
    cycles(10);
    rst = 1; cycle(); rst = 0;
    ch_en = 4'b0010;
    set_div(1, 100);
    cycles(50);
    set_div(1, 10);
    cycle();
    chk("t5_wrap", 32'(tick_o[1]), 1);
    cycles(10);
    chk("t5_quiet", 32'(tick_o[1]), 0);
    cycle();
    chk("t5_period", 32'(tick_o[1]), 1);
    ch_en = 4'b1111;
    pause_btn = 1; cycle(); pause_btn = 0;
    cycles(4);
    rst = 1; cycle(); rst = 0;
    chk("t6_all", {toggle_o, tick_o, paused_o}, 0);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) pause_btn = ~pause_btn;
      step_pulse = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) ch_en = N'($urandom);
      if ($urandom_range(0, 19) == 0) set_div($urandom_range(0, N - 1), $urandom_range(0, 12));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
